fft_pingpong_ram: RTL and testbench

Double-buffered sample memory for the 16-point FFT datapath, generalised in data width and depth. One bank accepts a streamed frame of input samples (optionally stored in bit-reversed order) while the other bank serves the butterfly engine through two write ports and two registered read ports. Banks swap under a load-full/compute-done handshake, so loading of frame N+1 overlaps computation on frame N.

---
 rtl/fft_pingpong_ram.sv | 118 +++++++++++
 tb/tb_fft_pingpong_ram.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fft_pingpong_ram.sv
// Double-buffered sample memory for the FFT datapath: one bank streams in the
// next frame while the other serves the butterfly engine on two write/read ports.
module fft_pingpong_ram #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 4,
  parameter int BITREV_LOAD = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  output logic              comp_start,
  output logic              comp_busy,
  input  logic              comp_done,
  output logic              comp_bank,
  input  logic [ADDR_W-1:0] write_addr_1,
  input  logic [ADDR_W-1:0] write_addr_2,
  input  logic [DATA_W-1:0] write_data_1,
  input  logic [DATA_W-1:0] write_data_2,
  input  logic              write_en_1,
  input  logic              write_en_2,
  input  logic [ADDR_W-1:0] read_addr_1,
  input  logic [ADDR_W-1:0] read_addr_2,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [0:2*DEPTH-1];
  logic [ADDR_W-1:0] r_load_cnt;
  logic              r_load_full;
  logic              r_comp_bank;
  logic              r_comp_busy;
  logic              r_comp_start;
  logic [DATA_W-1:0] r_read_data_1;
  logic [DATA_W-1:0] r_read_data_2;

  logic              w_xfer;
  logic              w_last;
  logic              w_full_next;
  logic              w_swap;
  logic [ADDR_W-1:0] w_load_addr;

  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    for (int k = 0; k < ADDR_W; k++) begin
      r[k] = a[ADDR_W-1-k];
    end
    return r;
  endfunction

  assign load_ready  = !r_load_full && !rst;
  assign w_xfer      = load_valid && load_ready;
  assign w_last      = w_xfer && (r_load_cnt == {ADDR_W{1'b1}});
  // Swap may happen on the very edge that completes the frame, so use the next-state full flag.
  assign w_full_next = r_load_full || w_last;
  assign w_swap      = w_full_next && (!r_comp_busy || comp_done);
  assign w_load_addr = (BITREV_LOAD != 0) ? bitrev(r_load_cnt) : r_load_cnt;

  // Load counter, bank ownership and compute handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_cnt   <= '0;
      r_load_full  <= 1'b0;
      r_comp_bank  <= 1'b0;
      r_comp_busy  <= 1'b0;
      r_comp_start <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_load_cnt <= w_last ? '0 : r_load_cnt + ADDR_W'(1);
      end
      r_comp_start <= w_swap;
      if (w_swap) begin
        r_comp_bank <= ~r_comp_bank;
        r_load_full <= 1'b0;
        r_comp_busy <= 1'b1;
      end else begin
        r_load_full <= w_full_next;
        if (comp_done) begin
          r_comp_busy <= 1'b0;
        end
      end
    end
  end

  // Storage writes; port 2 is written last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_mem[{~r_comp_bank, w_load_addr}] <= load_data;
    end
    if (r_comp_busy && write_en_1) begin
      r_mem[{r_comp_bank, write_addr_1}] <= write_data_1;
    end
    if (r_comp_busy && write_en_2) begin
      r_mem[{r_comp_bank, write_addr_2}] <= write_data_2;
    end
  end

  // Registered reads from the compute bank (old data on same-cycle write).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_read_data_1 <= '0;
      r_read_data_2 <= '0;
    end else begin
      r_read_data_1 <= r_mem[{r_comp_bank, read_addr_1}];
      r_read_data_2 <= r_mem[{r_comp_bank, read_addr_2}];
    end
  end

  assign comp_start  = r_comp_start;
  assign comp_busy   = r_comp_busy;
  assign comp_bank   = r_comp_bank;
  assign read_data_1 = r_read_data_1;
  assign read_data_2 = r_read_data_2;

endmodule

// File: tb/tb_fft_pingpong_ram.sv
// Scoreboard bench for fft_pingpong_ram: a bench-side memory model predicts
// read data, pushed on issue and popped when the registered read appears.
module tb_fft_pingpong_ram;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_valid;
  logic          load_ready;
  logic [DW-1:0] load_data;
  logic          comp_start;
  logic          comp_busy;
  logic          comp_done;
  logic          comp_bank;
  logic [AW-1:0] write_addr_1, write_addr_2;
  logic [DW-1:0] write_data_1, write_data_2;
  logic          write_en_1, write_en_2;
  logic [AW-1:0] read_addr_1, read_addr_2;
  logic [DW-1:0] read_data_1, read_data_2;

  int n_total = 0;
  int n_bad   = 0;
  logic [DW-1:0] exp_mem [0:31];
  logic [DW-1:0] exp_q [$];

  fft_pingpong_ram #(.DATA_W(DW), .ADDR_W(AW), .BITREV_LOAD(1)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .comp_start(comp_start), .comp_busy(comp_busy), .comp_done(comp_done),
    .comp_bank(comp_bank),
    .write_addr_1(write_addr_1), .write_addr_2(write_addr_2),
    .write_data_1(write_data_1), .write_data_2(write_data_2),
    .write_en_1(write_en_1), .write_en_2(write_en_2),
    .read_addr_1(read_addr_1), .read_addr_2(read_addr_2),
    .read_data_1(read_data_1), .read_data_2(read_data_2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rev4(input int a);
    int r = 0;
    for (int k = 0; k < 4; k++) r = (r << 1) | ((a >> k) & 1);
    return r;
  endfunction

  // One load transfer of sample index idx into load bank lb.
  task automatic load_one(input logic [DW-1:0] d, input int idx, input int lb);
    chk("load_ready_pre", {63'd0, load_ready}, 64'd1);
    load_valid = 1'b1;
    load_data  = d;
    exp_mem[lb*16 + rev4(idx)] = d;
    step();
    load_valid = 1'b0;
  endtask

  // Issue a read on port p, predict data from the model, compare one cycle later.
  task automatic do_read(input string tag, input int p, input int bank, input int addr);
    if (p == 1) read_addr_1 = AW'(addr);
    else        read_addr_2 = AW'(addr);
    exp_q.push_back(exp_mem[bank*16 + addr]);
    step();
    chk(tag, (p == 1) ? {32'd0, read_data_1} : {32'd0, read_data_2}, {32'd0, exp_q.pop_front()});
  endtask

  initial begin
    rst = 1'b1; load_valid = 1'b0; load_data = '0; comp_done = 1'b0;
    write_addr_1 = '0; write_addr_2 = '0; write_data_1 = '0; write_data_2 = '0;
    write_en_1 = 1'b0; write_en_2 = 1'b0; read_addr_1 = '0; read_addr_2 = '0;
    for (int i = 0; i < 32; i++) exp_mem[i] = '0;

    // Reset state
    repeat (3) step();
    chk("rst_ready", {63'd0, load_ready}, 64'd0);
    chk("rst_bank",  {63'd0, comp_bank}, 64'd0);
    chk("rst_busy",  {63'd0, comp_busy}, 64'd0);
    chk("rst_start", {63'd0, comp_start}, 64'd0);
    chk("rst_rd1",   {32'd0, read_data_1}, 64'd0);
    chk("rst_rd2",   {32'd0, read_data_2}, 64'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {63'd0, load_ready}, 64'd1);

    // Frame A, compute idle: swap on the 16th transfer edge
    for (int i = 0; i < 15; i++) load_one(DW'(i), i, 1);
    chk("a_no_start_yet", {63'd0, comp_start}, 64'd0);
    load_one(DW'(15), 15, 1);
    chk("a_start", {63'd0, comp_start}, 64'd1);
    chk("a_bank",  {63'd0, comp_bank}, 64'd1);
    chk("a_busy",  {63'd0, comp_busy}, 64'd1);
    step();
    chk("a_start_pulse", {63'd0, comp_start}, 64'd0);
    do_read("a_rd_addr8", 1, 1, 8);
    do_read("a_rd_addr0", 2, 1, 0);
    do_read("a_rd_addr15", 1, 1, 15);

    // Write collision on address 5
    write_en_1 = 1'b1; write_en_2 = 1'b1; write_addr_1 = 4'd5; write_addr_2 = 4'd5;
    write_data_1 = 32'hAAAA_AAAA; write_data_2 = 32'h5555_5555;
    step();
    write_en_1 = 1'b0; write_en_2 = 1'b0;
    exp_mem[16 + 5] = 32'h5555_5555;
    do_read("collide_addr5", 1, 1, 5);

    // Read-before-write on address 3
    write_en_1 = 1'b1; write_addr_1 = 4'd3; write_data_1 = 32'h0000_1234;
    do_read("rbw_old", 1, 1, 3);
    write_en_1 = 1'b0;
    exp_mem[16 + 3] = 32'h0000_1234;
    do_read("rbw_new", 2, 1, 3);

    // Frame B loads while A computes; held off until comp_done
    for (int i = 0; i < 16; i++) load_one(DW'(100 + i), i, 0);
    chk("b_full_ready", {63'd0, load_ready}, 64'd0);
    chk("b_bank_held",  {63'd0, comp_bank}, 64'd1);
    load_valid = 1'b1; load_data = 32'd999;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("b_ready_stays0", {63'd0, load_ready}, 64'd0);
      chk("b_no_start", {63'd0, comp_start}, 64'd0);
    end
    load_valid = 1'b0;
    comp_done = 1'b1;
    step();
    comp_done = 1'b0;
    chk("b_bank", {63'd0, comp_bank}, 64'd0);
    chk("b_start", {63'd0, comp_start}, 64'd1);
    chk("b_busy", {63'd0, comp_busy}, 64'd1);
    chk("b_ready", {63'd0, load_ready}, 64'd1);
    do_read("b_rd_addr8", 1, 0, 8);
    chk("b_start_pulse", {63'd0, comp_start}, 64'd0);
    do_read("b_rd_addr0", 2, 0, 0);

    // comp_done without swap, then dropped writes and ignored comp_done
    comp_done = 1'b1;
    step();
    comp_done = 1'b0;
    chk("done_busy0", {63'd0, comp_busy}, 64'd0);
    chk("done_bank", {63'd0, comp_bank}, 64'd0);
    write_en_1 = 1'b1; write_addr_1 = 4'd2; write_data_1 = 32'hDEAD_BEEF;
    write_en_2 = 1'b1; write_addr_2 = 4'd8; write_data_2 = 32'hFEED_F00D;
    step();
    write_en_1 = 1'b0; write_en_2 = 1'b0;
    do_read("idle_wr_drop2", 1, 0, 2);
    do_read("idle_wr_drop8", 2, 0, 8);
    comp_done = 1'b1;
    step();
    comp_done = 1'b0;
    chk("idle_done_busy", {63'd0, comp_busy}, 64'd0);
    chk("idle_done_bank", {63'd0, comp_bank}, 64'd0);
    chk("idle_done_start", {63'd0, comp_start}, 64'd0);

    // Reset mid-frame: 7 samples into bank 1, then reset
    for (int i = 0; i < 7; i++) load_one(DW'(50 + i), i, 1);
    rst = 1'b1;
    step();
    chk("mid_rst_ready", {63'd0, load_ready}, 64'd0);
    chk("mid_rst_bank",  {63'd0, comp_bank}, 64'd0);
    chk("mid_rst_busy",  {63'd0, comp_busy}, 64'd0);
    chk("mid_rst_start", {63'd0, comp_start}, 64'd0);
    chk("mid_rst_rd1",   {32'd0, read_data_1}, 64'd0);
    rst = 1'b0;
    step();
    for (int i = 0; i < 16; i++) load_one(DW'(200 + i), i, 1);
    chk("c_start", {63'd0, comp_start}, 64'd1);
    chk("c_bank",  {63'd0, comp_bank}, 64'd1);
    chk("c_busy",  {63'd0, comp_busy}, 64'd1);
    do_read("c_rd_addr8", 1, 1, 8);
    do_read("c_rd_addr0", 2, 1, 0);
    do_read("c_rd_addr6", 1, 1, 6);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
